// File: rtl/sipo_pkg.sv
// ============================================================================
// Module : sipo_pkg
// Brief  : Shared state encoding and word-geometry constants for the
//          sipo_deserializer (parity framing enabled by SIPO_PARITY_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Serial bits per frame: data bits plus the optional parity bit.
    function automatic int bits_per_word(input int width);
`ifdef SIPO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_bit_counter.sv
// ============================================================================
// Module : sipo_bit_counter
// Brief  : Frame bit counter with clear, enable and terminal-count output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_bit_counter #(
    parameter int TERMINAL = 3,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_tc    = (r_count == CNT_W'(TERMINAL));
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/sipo_deserializer.sv
// ============================================================================
// Module : sipo_deserializer
// Brief  : LSB-first serial-in parallel-out deserializer with ready/valid
//          output, sticky overflow and optional even parity (SIPO_PARITY_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overflow,
    output logic             parity_err
);

    localparam int c_nbits = bits_per_word(WIDTH);
    localparam int c_cnt_w = $clog2(c_nbits + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] w_count;
    logic               w_tc;
    logic               w_accept;
    logic               w_complete;
    logic               w_deliver;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH-1:0]   r_q;
    logic               r_q_valid;
    logic               r_overflow;

    assign w_accept = sin_valid & ~flush;

    sipo_bit_counter #(
        .TERMINAL (c_nbits - 1),
        .CNT_W    (c_cnt_w)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (flush),
        .i_en    (w_accept),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else if (sin_valid) begin
            if (w_tc) begin
                w_state_next = ST_IDLE;
`ifdef SIPO_PARITY_EN
            end else if (w_count == c_cnt_w'(WIDTH - 1)) begin
                w_state_next = ST_PARITY;
`endif
            end else begin
                w_state_next = ST_SHIFT;
            end
        end
    end

    // Drop the incoming bit into the slot selected by the running count.
    always_comb begin
        w_shift_next = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_state != ST_PARITY && w_count == c_cnt_w'(i)) begin
                w_shift_next[i] = sin;
            end
        end
    end

    assign w_complete = w_accept & w_tc;

`ifdef SIPO_PARITY_EN
    logic w_good;
    logic r_parity_err;

    assign w_word    = r_shift;
    assign w_good    = ~(^r_shift ^ sin);
    assign w_deliver = w_complete & w_good;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_complete & ~w_good;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign w_word     = w_shift_next;
    assign w_deliver  = w_complete;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset || flush || w_complete) begin
            r_shift <= '0;
        end else if (w_accept) begin
            r_shift <= w_shift_next;
        end
    end

    // A finished word replaces q only if the slot is free or being drained.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_deliver) begin
            if (!r_q_valid || q_ready) begin
                r_q       <= w_word;
                r_q_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (r_q_valid && q_ready) begin
            r_q_valid <= 1'b0;
        end
    end

    assign q        = r_q;
    assign q_valid  = r_q_valid;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, number of data bits per word.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset (reset=0 resets on next clk edge).
REQ-004 SHALL have port: sin  input  1  serial data bit.
REQ-005 SHALL have port: sin_valid  input  1  sin is sampled on this edge when 1.
REQ-006 SHALL have port: flush  input  1  discard partially assembled word.
REQ-007 SHALL have port: q  output  WIDTH  parallel word to the downstream PIPO register.
REQ-008 SHALL have port: q_valid  output  1  q holds an unconsumed word.
REQ-009 SHALL have port: q_ready  input  1  downstream accepts q when q_valid=1.
REQ-010 SHALL have port: overflow  output  1  sticky, a completed word was dropped.
REQ-011 SHALL have port: parity_err  output  1  one-cycle pulse on bad parity.

Function
REQ-012 SHALL implement states IDLE (bit count 0), SHIFT (1..WIDTH-1 bits held) and, with parity enabled, PARITY (WIDTH data bits held, awaiting parity bit).
REQ-013 SHALL shift LSB-first: the k-th accepted bit (k=0..WIDTH-1) lands at bit position k of the word.
REQ-014 SHALL hold the count, state and partial word unchanged on any cycle with sin_valid=0.
REQ-015 SHALL, on the edge accepting the final bit of a word, load the word into q and set q_valid=1 (visible the cycle after that edge); the count returns to 0 and the state to IDLE on the same edge.
REQ-016 SHALL keep q and q_valid stable while q_valid=1 and q_ready=0.
REQ-017 SHALL clear q_valid on an edge with q_valid=1 and q_ready=1 unless a new word completes on that edge, in which case q takes the new word and q_valid stays 1.
REQ-018 SHALL, when a word completes while q_valid=1 and q_ready=0, drop the new word, keep q unchanged and set overflow=1.
REQ-019 SHALL keep overflow=1 until reset; no other clear.
REQ-020 SHALL, on flush=1, clear the count and partial word and enter IDLE; any bit presented with sin_valid on that edge is discarded; q, q_valid and overflow are unaffected.
REQ-021 SHALL give flush priority over sin_valid, and reset priority over all inputs.
REQ-022 SHALL accept back-to-back words with no idle cycle between the last bit of one word and the first bit of the next.

Reset
REQ-023 SHALL, on an edge with reset=0, set q=0, q_valid=0, overflow=0, parity_err=0, count=0, partial word=0, state=IDLE, aborting any word in progress.

Configuration
REQ-024 SHALL, with macro SIPO_PARITY_EN defined, expect one even-parity bit after the WIDTH data bits; the word is delivered per REQ-015..018 on the edge accepting a correct parity bit.
REQ-025 SHALL, with SIPO_PARITY_EN defined and parity wrong, drop the word, leave q/q_valid/overflow unchanged and pulse parity_err=1 for exactly one cycle.
REQ-026 SHALL, without SIPO_PARITY_EN, omit the PARITY state, deliver on the WIDTH-th bit, and drive parity_err constant 0 (port retained).

Structure
REQ-027 SHALL place the state enumeration typedef and the default WIDTH constant in shared package sipo_pkg.
REQ-028 SHALL use one sub-module, sipo_bit_counter, holding the bit count with clear (flush/reset) and enable (sin_valid) inputs and a terminal-count output.

Verification (WIDTH=4)
REQ-029 SHALL verify: reset=0 for 2 cycles mid-word -> q=0000, q_valid=0, overflow=0, next word assembles from bit 0.
REQ-030 SHALL verify: sin=1,1,0,1 on 4 consecutive sin_valid cycles, q_ready=1 -> q=1011, q_valid=1 for exactly one cycle.
REQ-031 SHALL verify: bits 0,1,0,0 with 3 sin_valid=0 cycles after the 2nd bit -> q=0010, arriving 3 cycles later than without gaps.
REQ-032 SHALL verify: q_ready=0, words 1001 then 0001 -> q stays 1001, overflow=1; then q_ready=1 -> q_valid drops, overflow stays 1.
REQ-033 SHALL verify: bits 1,1 then flush=1, then 1,1,0,1 -> q=1011, no word emitted at flush.
REQ-034 SHALL verify (SIPO_PARITY_EN): 1,1,0,1 + parity 1 -> q=1011 delivered; 1,1,0,1 + parity 0 -> parity_err pulse, q_valid stays 0.
